// File: rtl/prince_share_masker.sv
// Boundary of the 3-share masked PRINCE datapath: splits a plaintext state into
// three Boolean shares one nibble per random byte, and recombines shares on the way out.
module prince_share_masker #(
    parameter int NIBBLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [7:0]           rnd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] share_a,
    output logic [4*NIBBLES-1:0] share_b,
    output logic [4*NIBBLES-1:0] share_c,
    input  logic                 um_in_valid,
    input  logic [4*NIBBLES-1:0] um_a,
    input  logic [4*NIBBLES-1:0] um_b,
    input  logic [4*NIBBLES-1:0] um_c,
    output logic                 um_out_valid,
    output logic [4*NIBBLES-1:0] um_data
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MASK = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_x;
    logic          r_um_valid;
    logic [W-1:0]  r_um_data;
    logic          w_take;

    assign in_ready  = (r_state == ST_IDLE);
    assign rnd_ready = (r_state == ST_MASK);
    assign out_valid = (r_state == ST_OUT);
    assign w_take    = rnd_ready && rnd_valid;

    // Plaintext is wiped on the edge that masks the final nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_data;
                        r_cnt   <= '0;
                        r_state <= ST_MASK;
                    end
                end
                ST_MASK: begin
                    if (rnd_valid) begin
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_x     <= '0;
                            r_state <= ST_OUT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            logic       w_we;
            logic [3:0] w_x;
            logic [3:0] r_a;
            logic [3:0] r_b;
            logic [3:0] r_c;

            assign w_we = w_take && (r_cnt == CW'(gi));
            assign w_x  = r_x[4*gi +: 4];

            // Only share_c ever sees the plaintext, and only via this XOR.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_c <= '0;
                end else if (w_we) begin
                    r_a <= rnd_data[3:0];
                    r_b <= rnd_data[7:4];
                    r_c <= w_x ^ rnd_data[3:0] ^ rnd_data[7:4];
                end
            end

            assign share_a[4*gi +: 4] = r_a;
            assign share_b[4*gi +: 4] = r_b;
            assign share_c[4*gi +: 4] = r_c;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_um_valid <= 1'b0;
            r_um_data  <= '0;
        end else begin
            r_um_valid <= um_in_valid;
            if (um_in_valid) begin
                r_um_data <= um_a ^ um_b ^ um_c;
            end
        end
    end

    assign um_out_valid = r_um_valid;
    assign um_data      = r_um_data;

endmodule
